load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 210 +++++++++++++++++++++
 tb/tb_load_store_unit.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Single-outstanding load/store engine between a CPU pipeline and a
//            simple req/ack memory bus. Checks alignment/legality, forms the
//            word-aligned bus address, byte enables and replicated write data,
//            waits for bus_ack with a timeout, and extracts/extends load data.
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            start               - memory instruction valid (sampled in IDLE)
//            mem_read/mem_write  - access type from the decoder
//            mem_width           - 00 byte, 01 half, 10 word, 11 illegal
//            load_unsigned       - zero-extend loads when 1
//            addr, store_data    - byte address and store source
//            busy, done, fault   - PC stall, completion pulse, error pulse
//            load_data           - last completed load result
//            bus_*               - memory bus request/response
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_width,
  input  logic        load_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] load_data,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  // Counter holds the number of completed WAIT cycles, 0 .. TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [31:0]      bus_addr_q, bus_addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic [1:0]       lane_q, lane_d;
  logic [1:0]       width_q, width_d;
  logic             uns_q, uns_d;
  logic             fault_q, fault_d;
  logic [31:0]      load_data_q, load_data_d;

  logic             legal_w;
  logic [3:0]       be_w;
  logic [31:0]      wdata_w;
  logic [7:0]       rbyte_w;
  logic [15:0]      rhalf_w;
  logic [31:0]      load_ext_w;

  // Request legality and bus lane formation from the live inputs.
  always_comb begin
    legal_w = (mem_read ^ mem_write) && (mem_width != 2'b11);
    if (mem_width == 2'b01 && addr[0])
      legal_w = 1'b0;
    if (mem_width == 2'b10 && addr[1:0] != 2'b00)
      legal_w = 1'b0;

    be_w    = 4'b1111;
    wdata_w = store_data;
    case (mem_width)
      2'b00: begin
        be_w    = 4'b0001 << addr[1:0];
        wdata_w = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_w    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_w = {2{store_data[15:0]}};
      end
      default: begin
        be_w    = 4'b1111;
        wdata_w = store_data;
      end
    endcase
  end

  // Load lane selection and extension using the latched request attributes.
  always_comb begin
    case (lane_q)
      2'd0:    rbyte_w = bus_rdata[7:0];
      2'd1:    rbyte_w = bus_rdata[15:8];
      2'd2:    rbyte_w = bus_rdata[23:16];
      default: rbyte_w = bus_rdata[31:24];
    endcase
    rhalf_w = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];

    case (width_q)
      2'b00:   load_ext_w = {{24{~uns_q & rbyte_w[7]}}, rbyte_w};
      2'b01:   load_ext_w = {{16{~uns_q & rhalf_w[15]}}, rhalf_w};
      default: load_ext_w = bus_rdata;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    bus_addr_d  = bus_addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    lane_d      = lane_q;
    width_d     = width_q;
    uns_d       = uns_q;
    fault_d     = 1'b0;
    load_data_d = load_data_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          we_d       = mem_write;
          bus_addr_d = {addr[31:2], 2'b00};
          wdata_d    = wdata_w;
          be_d       = be_w;
          lane_d     = addr[1:0];
          width_d    = mem_width;
          uns_d      = load_unsigned;
          if (legal_w) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end else begin
            fault_d = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        // An ack in the final allowed cycle takes priority over the timeout.
        if (bus_ack) begin
          state_d = ST_RESP;
          if (!we_q)
            load_data_d = load_ext_w;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      bus_addr_q  <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      lane_q      <= '0;
      width_q     <= '0;
      uns_q       <= 1'b0;
      fault_q     <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      bus_addr_q  <= bus_addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      lane_q      <= lane_d;
      width_q     <= width_d;
      uns_q       <= uns_d;
      fault_q     <= fault_d;
      load_data_q <= load_data_d;
    end
  end

  // bus_req derives from the state register so an async reset drops it at once.
  assign bus_req   = (state_q == ST_WAIT);
  assign done      = (state_q == ST_RESP);
  assign fault     = fault_q;
  assign busy      = (state_q != ST_IDLE) || (start && legal_w);
  assign bus_we    = we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = wdata_q;
  assign bus_be    = be_q;
  assign load_data = load_data_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Self-checking bench for load_store_unit: directed literal cases
//            followed by randomized traffic compared every cycle against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  mem_width = 2'b00;
  logic        load_unsigned = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  logic        busy, done, fault;
  logic [31:0] load_data;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_read(mem_read),
    .mem_write(mem_write), .mem_width(mem_width), .load_unsigned(load_unsigned),
    .addr(addr), .store_data(store_data), .busy(busy), .done(done),
    .fault(fault), .load_data(load_data), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic bit f_legal(bit rd, bit wr, logic [1:0] w, logic [31:0] a);
    if (rd == wr) return 0;
    if (w == 3) return 0;
    if (w == 1 && (a % 2) != 0) return 0;
    if (w == 2 && (a % 4) != 0) return 0;
    return 1;
  endfunction

  function automatic logic [3:0] f_be(logic [1:0] w, logic [31:0] a);
    if (w == 0) return 4'(1 << (a % 4));
    if (w == 1) return ((a % 4) >= 2) ? 4'd12 : 4'd3;
    return 4'd15;
  endfunction

  function automatic logic [31:0] f_wdata(logic [1:0] w, logic [31:0] d);
    if (w == 0) return (d & 32'hFF) * 32'h01010101;
    if (w == 1) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] f_load(logic [1:0] w, bit u, logic [31:0] a, logic [31:0] r);
    logic [31:0] v;
    if (w == 0) begin
      v = (r >> (8 * (a % 4))) & 32'hFF;
      if (!u && v >= 128) v = v - 32'd256;
    end else if (w == 1) begin
      v = (r >> (16 * ((a % 4) / 2))) & 32'hFFFF;
      if (!u && v >= 32768) v = v - 32'd65536;
    end else begin
      v = r;
    end
    return v;
  endfunction

  // ---------------- transaction-level model ----------------
  // phase: 0 idle, 1 bus transfer outstanding, 2 completion cycle
  int          m_phase = 0;
  int          m_waited = 0;
  bit          m_we = 0;
  logic [1:0]  m_w = 0;
  bit          m_u = 0;
  logic [31:0] m_a = 0;
  logic [31:0] m_baddr = 0, m_wdata = 0, m_ld = 0;
  logic [3:0]  m_be = 0;
  bit          m_fault = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_waited = 0; m_we = 0; m_w = 0; m_u = 0; m_a = 0;
      m_baddr = 0; m_wdata = 0; m_be = 0; m_ld = 0; m_fault = 0;
    end else begin
      m_fault = 0;
      if (m_phase == 0) begin
        if (start) begin
          m_we = mem_write; m_w = mem_width; m_u = load_unsigned; m_a = addr;
          m_baddr = addr - (addr % 4);
          m_be = f_be(mem_width, addr);
          m_wdata = f_wdata(mem_width, store_data);
          if (f_legal(mem_read, mem_write, mem_width, addr)) begin
            m_phase = 1; m_waited = 0;
          end else begin
            m_fault = 1;
          end
        end
      end else if (m_phase == 1) begin
        if (bus_ack) begin
          if (!m_we) m_ld = f_load(m_w, m_u, m_a, bus_rdata);
          m_phase = 2;
        end else begin
          m_waited = m_waited + 1;
          if (m_waited >= TO) begin
            m_phase = 0; m_fault = 1;
          end
        end
      end else begin
        m_phase = 0;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_bus_req", bus_req, 0);
      chk("rst_bus_we", bus_we, 0);
      chk("rst_bus_addr", bus_addr, 0);
      chk("rst_bus_wdata", bus_wdata, 0);
      chk("rst_bus_be", bus_be, 0);
      chk("rst_done", done, 0);
      chk("rst_fault", fault, 0);
      chk("rst_load_data", load_data, 0);
    end else begin
      chk("bus_req", bus_req, m_phase == 1);
      chk("done", done, m_phase == 2);
      chk("fault", fault, m_fault);
      chk("load_data", load_data, m_ld);
      chk("bus_we", bus_we, m_we);
      chk("bus_addr", bus_addr, m_baddr);
      chk("bus_wdata", bus_wdata, m_wdata);
      chk("bus_be", bus_be, m_be);
      chk("busy", busy, (m_phase != 0) ||
          (start && f_legal(mem_read, mem_write, mem_width, addr)));
      chk("done_and_fault", done & fault, 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit rd, input bit wr, input logic [1:0] w, input bit u,
                         input logic [31:0] a, input logic [31:0] d);
    mem_read = rd; mem_write = wr; mem_width = w; load_unsigned = u;
    addr = a; store_data = d; start = 1'b1;
  endtask

  // Presents a request for one cycle; returns in the cycle after start.
  task automatic issue(input bit rd, input bit wr, input logic [1:0] w, input bit u,
                       input logic [31:0] a, input logic [31:0] d);
    set_req(rd, wr, w, u, a, d);
    step();
    start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) step();
    @(negedge clk);
    chk("reset_bus_be", bus_be, 4'b0000);
    chk("reset_load_data", load_data, 32'h0);
    step();
    rst = 1'b0;

    // Byte load, sign-extended, ack after two idle WAIT cycles
    issue(1, 0, 2'b00, 0, 32'h0000_1003, 32'h0);
    @(negedge clk);
    chk("byte_ld_bus_addr", bus_addr, 32'h0000_1000);
    chk("byte_ld_bus_be", bus_be, 4'b1000);
    chk("byte_ld_bus_req", bus_req, 1);
    step(); step();
    bus_ack = 1'b1; bus_rdata = 32'h80FF_1234;
    step();
    bus_ack = 1'b0;
    @(negedge clk);
    chk("byte_ld_done", done, 1);
    chk("byte_ld_data", load_data, 32'hFFFF_FF80);
    step();
    @(negedge clk);
    chk("byte_ld_done_single", done, 0);

    // Half load, unsigned, minimum latency
    step();
    issue(1, 0, 2'b01, 1, 32'h0000_2002, 32'h0);
    bus_ack = 1'b1; bus_rdata = 32'hBEEF_0000;
    @(negedge clk);
    chk("half_ld_bus_be", bus_be, 4'b1100);
    step();
    bus_ack = 1'b0;
    @(negedge clk);
    chk("half_ld_done", done, 1);
    chk("half_ld_data", load_data, 32'h0000_BEEF);

    // Byte store
    step();
    issue(0, 1, 2'b00, 0, 32'h0000_0011, 32'h1234_56AB);
    @(negedge clk);
    chk("st_bus_we", bus_we, 1);
    chk("st_bus_be", bus_be, 4'b0010);
    chk("st_bus_wdata", bus_wdata, 32'hABAB_ABAB);
    chk("st_bus_addr", bus_addr, 32'h0000_0010);
    bus_ack = 1'b1; bus_rdata = 32'h5555_5555;
    step();
    bus_ack = 1'b0;
    @(negedge clk);
    chk("st_done", done, 1);
    chk("st_load_data_kept", load_data, 32'h0000_BEEF);

    // Misaligned word
    step();
    set_req(1, 0, 2'b10, 0, 32'h0000_0006, 32'h0);
    @(negedge clk);
    chk("misal_busy", busy, 0);
    step();
    start = 1'b0;
    @(negedge clk);
    chk("misal_fault", fault, 1);
    chk("misal_bus_req", bus_req, 0);
    step();
    @(negedge clk);
    chk("misal_fault_single", fault, 0);

    // Read and write together
    set_req(1, 1, 2'b00, 0, 32'h0000_0040, 32'h0);
    step();
    start = 1'b0;
    @(negedge clk);
    chk("rdwr_fault", fault, 1);
    chk("rdwr_bus_req", bus_req, 0);

    // Timeout without ack
    step();
    issue(1, 0, 2'b10, 0, 32'h0000_0100, 32'h0);
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      chk("to_bus_req_held", bus_req, 1);
      step();
    end
    @(negedge clk);
    chk("to_bus_req_drop", bus_req, 0);
    chk("to_fault", fault, 1);
    chk("to_done", done, 0);
    step();
    @(negedge clk);
    chk("to_fault_single", fault, 0);

    // Ack in the final allowed WAIT cycle wins
    issue(1, 0, 2'b10, 0, 32'h0000_0104, 32'h0);
    for (int i = 0; i < TO - 1; i++) step();
    bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("last_ack_bus_req", bus_req, 1);
    step();
    bus_ack = 1'b0;
    @(negedge clk);
    chk("last_ack_done", done, 1);
    chk("last_ack_fault", fault, 0);
    chk("last_ack_data", load_data, 32'hCAFE_F00D);
    step();
    @(negedge clk);
    chk("last_ack_no_late_fault", fault, 0);

    // Reset in WAIT, then immediate new request
    issue(0, 1, 2'b10, 0, 32'h0000_0200, 32'h1111_2222);
    step();
    rst = 1'b1;
    #1;
    chk("rstwait_bus_req", bus_req, 0);
    chk("rstwait_bus_be", bus_be, 0);
    chk("rstwait_load_data", load_data, 0);
    step();
    rst = 1'b0;
    set_req(1, 0, 2'b10, 1, 32'h0000_0300, 32'h0);
    @(negedge clk);
    chk("rstwait_no_done", done, 0);
    chk("rstwait_no_fault", fault, 0);
    step();
    start = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("post_rst_bus_req", bus_req, 1);
    step();
    bus_ack = 1'b0;
    @(negedge clk);
    chk("post_rst_done", done, 1);
    chk("post_rst_data", load_data, 32'h1234_5678);
    step();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int t;
      t = int'($urandom_range(0, 7));
      start         = ($urandom_range(0, 2) == 0);
      mem_read      = (t == 0) || (t >= 2 && t <= 4);
      mem_write     = (t == 0) || (t >= 5);
      mem_width     = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      load_unsigned = 1'($urandom);
      addr          = $urandom;
      store_data    = $urandom;
      bus_ack       = ($urandom_range(0, 2) == 0);
      bus_rdata     = $urandom;
      rst           = ($urandom_range(0, 249) == 0);
      step();
    end
    rst = 1'b0; start = 1'b0; bus_ack = 1'b0;
    repeat (TO + 3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
